// File: rtl/miss_fill_ctrl_if.sv
// miss_fill_ctrl_if: cache miss requests, memory read port and cache fill port of miss_fill_ctrl.
interface miss_fill_ctrl_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
  logic              icache_miss;
  logic [ADDR_W-1:0] icache_miss_addr;
  logic              dcache_miss;
  logic [ADDR_W-1:0] dcache_miss_addr;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_data;
  logic              icache_fill_we;
  logic              dcache_fill_we;
  logic [2:0]        fill_idx;
  logic [DATA_W-1:0] fill_data;
  logic [ADDR_W-1:0] fill_base;
  logic              icache_fill_done;
  logic              dcache_fill_done;
  logic              busy;
  modport master (
    input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, icache_fill_we, dcache_fill_we, fill_idx, fill_data, fill_base,
           icache_fill_done, dcache_fill_done, busy
  );
  modport slave (
    output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr, mem_data_valid, mem_data,
    input  mem_en, mem_addr, icache_fill_we, dcache_fill_we, fill_idx, fill_data, fill_base,
           icache_fill_done, dcache_fill_done, busy
  );
endinterface

// File: rtl/miss_fill_ctrl.sv
// miss_fill_ctrl: I/D-cache block-fill sequencer (8 word reads per 16-byte block, D-cache priority).
// Define MISS_FILL_CWF_EN to issue the missing word first and wrap; otherwise words go out 0..7.
module miss_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic             clk,
  input logic             rst,
  miss_fill_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state, nextState;
  logic              sel;
  logic [ADDR_W-1:0] fillBase;
  logic [ADDR_W-1:0] missAddr;
  logic [2:0]        start, startNext, txCnt, rxCnt, issueIdx, fillIdx;
  logic              grant, accept;
  always_comb begin
    grant     = state == IDLE && (bus.dcache_miss || bus.icache_miss);
    missAddr  = bus.dcache_miss ? bus.dcache_miss_addr : bus.icache_miss_addr;
`ifdef MISS_FILL_CWF_EN
    startNext = missAddr[3:1];
`else
    startNext = 3'd0;
`endif
    accept    = (state == ISSUE || state == WAIT) && bus.mem_data_valid;
    issueIdx  = start + txCnt;
    fillIdx   = start + rxCnt;
    nextState = state;
    case (state)
      IDLE:  nextState = grant ? ISSUE : IDLE;
      ISSUE: nextState = accept && rxCnt == 3'd7 ? DONE : (txCnt == 3'd7 ? WAIT : ISSUE);
      WAIT:  nextState = accept && rxCnt == 3'd7 ? DONE : WAIT;
      DONE:  nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      fillBase <= '0;
      start    <= 3'd0;
      txCnt    <= 3'd0;
      rxCnt    <= 3'd0;
    end else begin
      state <= nextState;
      if (grant) begin
        sel      <= bus.dcache_miss;
        fillBase <= missAddr & ~ADDR_W'(15);
        start    <= startNext;
        txCnt    <= 3'd0;
        rxCnt    <= 3'd0;
      end
      if (state == ISSUE) txCnt <= txCnt + 3'd1;
      if (accept) rxCnt <= rxCnt + 3'd1;
    end
  end
  // Fill outputs are gated so they read zero outside an accepted return.
  assign bus.mem_en           = state == ISSUE;
  assign bus.mem_addr         = bus.mem_en ? {fillBase[ADDR_W-1:4], issueIdx, 1'b0} : '0;
  assign bus.dcache_fill_we   = accept && sel;
  assign bus.icache_fill_we   = accept && !sel;
  assign bus.fill_idx         = accept ? fillIdx : 3'd0;
  assign bus.fill_data        = accept ? bus.mem_data : DATA_W'(0);
  assign bus.fill_base        = fillBase;
  assign bus.dcache_fill_done = state == DONE && sel;
  assign bus.icache_fill_done = state == DONE && !sel;
  assign bus.busy             = state != IDLE;
endmodule
